// File: rtl/veerwolf_axi_pkg.sv
// Shared AXI constants, payload widths and buffer occupancy type
// for the register slice and its skid buffers.
package veerwolf_axi_pkg;

    localparam int ADDR_WIDTH  = 32;
    localparam int DATA_WIDTH  = 64;
    localparam int STRB_WIDTH  = 8;
    localparam int LEN_WIDTH   = 8;
    localparam int SIZE_WIDTH  = 3;
    localparam int BURST_WIDTH = 2;
    localparam int RESP_WIDTH  = 2;

    // W carries data, strobes and last; it has no ID.
    localparam int W_WIDTH = DATA_WIDTH + STRB_WIDTH + 1;

    function automatic int ax_width(input int id_width);
        return ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH + id_width;
    endfunction

    function automatic int b_width(input int id_width);
        return RESP_WIDTH + id_width;
    endfunction

    function automatic int r_width(input int id_width);
        return DATA_WIDTH + RESP_WIDTH + 1 + id_width;
    endfunction

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

endpackage

// File: rtl/axi_reg_slice_if.sv
// Upstream and downstream AXI signals of the register slice; the slave
// modport is the slice's own view, the master modport the environment's.
interface axi_reg_slice_if
    import veerwolf_axi_pkg::*;
#(
    parameter int ID_WIDTH = 1
);

    logic [ID_WIDTH-1:0]    i_awid;
    logic [ADDR_WIDTH-1:0]  i_awaddr;
    logic [LEN_WIDTH-1:0]   i_awlen;
    logic [SIZE_WIDTH-1:0]  i_awsize;
    logic [BURST_WIDTH-1:0] i_awburst;
    logic                   i_awvalid;
    logic                   o_awready;

    logic [ID_WIDTH-1:0]    i_arid;
    logic [ADDR_WIDTH-1:0]  i_araddr;
    logic [LEN_WIDTH-1:0]   i_arlen;
    logic [SIZE_WIDTH-1:0]  i_arsize;
    logic [BURST_WIDTH-1:0] i_arburst;
    logic                   i_arvalid;
    logic                   o_arready;

    logic [DATA_WIDTH-1:0]  i_wdata;
    logic [STRB_WIDTH-1:0]  i_wstrb;
    logic                   i_wlast;
    logic                   i_wvalid;
    logic                   o_wready;

    logic [ID_WIDTH-1:0]    o_bid;
    logic [RESP_WIDTH-1:0]  o_bresp;
    logic                   o_bvalid;
    logic                   i_bready;

    logic [ID_WIDTH-1:0]    o_rid;
    logic [DATA_WIDTH-1:0]  o_rdata;
    logic [RESP_WIDTH-1:0]  o_rresp;
    logic                   o_rlast;
    logic                   o_rvalid;
    logic                   i_rready;

    logic [ID_WIDTH-1:0]    o_m_awid;
    logic [ADDR_WIDTH-1:0]  o_m_awaddr;
    logic [LEN_WIDTH-1:0]   o_m_awlen;
    logic [SIZE_WIDTH-1:0]  o_m_awsize;
    logic [BURST_WIDTH-1:0] o_m_awburst;
    logic                   o_m_awvalid;
    logic                   i_m_awready;

    logic [ID_WIDTH-1:0]    o_m_arid;
    logic [ADDR_WIDTH-1:0]  o_m_araddr;
    logic [LEN_WIDTH-1:0]   o_m_arlen;
    logic [SIZE_WIDTH-1:0]  o_m_arsize;
    logic [BURST_WIDTH-1:0] o_m_arburst;
    logic                   o_m_arvalid;
    logic                   i_m_arready;

    logic [DATA_WIDTH-1:0]  o_m_wdata;
    logic [STRB_WIDTH-1:0]  o_m_wstrb;
    logic                   o_m_wlast;
    logic                   o_m_wvalid;
    logic                   i_m_wready;

    logic [ID_WIDTH-1:0]    i_m_bid;
    logic [RESP_WIDTH-1:0]  i_m_bresp;
    logic                   i_m_bvalid;
    logic                   o_m_bready;

    logic [ID_WIDTH-1:0]    i_m_rid;
    logic [DATA_WIDTH-1:0]  i_m_rdata;
    logic [RESP_WIDTH-1:0]  i_m_rresp;
    logic                   i_m_rlast;
    logic                   i_m_rvalid;
    logic                   o_m_rready;

    modport slave (
        input  i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
        output o_awready,
        input  i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
        output o_arready,
        input  i_wdata, i_wstrb, i_wlast, i_wvalid,
        output o_wready,
        output o_bid, o_bresp, o_bvalid,
        input  i_bready,
        output o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
        input  i_rready,
        output o_m_awid, o_m_awaddr, o_m_awlen, o_m_awsize, o_m_awburst, o_m_awvalid,
        input  i_m_awready,
        output o_m_arid, o_m_araddr, o_m_arlen, o_m_arsize, o_m_arburst, o_m_arvalid,
        input  i_m_arready,
        output o_m_wdata, o_m_wstrb, o_m_wlast, o_m_wvalid,
        input  i_m_wready,
        input  i_m_bid, i_m_bresp, i_m_bvalid,
        output o_m_bready,
        input  i_m_rid, i_m_rdata, i_m_rresp, i_m_rlast, i_m_rvalid,
        output o_m_rready
    );

    modport master (
        output i_awid, i_awaddr, i_awlen, i_awsize, i_awburst, i_awvalid,
        input  o_awready,
        output i_arid, i_araddr, i_arlen, i_arsize, i_arburst, i_arvalid,
        input  o_arready,
        output i_wdata, i_wstrb, i_wlast, i_wvalid,
        input  o_wready,
        input  o_bid, o_bresp, o_bvalid,
        output i_bready,
        input  o_rid, o_rdata, o_rresp, o_rlast, o_rvalid,
        output i_rready,
        input  o_m_awid, o_m_awaddr, o_m_awlen, o_m_awsize, o_m_awburst, o_m_awvalid,
        output i_m_awready,
        input  o_m_arid, o_m_araddr, o_m_arlen, o_m_arsize, o_m_arburst, o_m_arvalid,
        output i_m_arready,
        input  o_m_wdata, o_m_wstrb, o_m_wlast, o_m_wvalid,
        output i_m_wready,
        output i_m_bid, i_m_bresp, i_m_bvalid,
        input  o_m_bready,
        output i_m_rid, i_m_rdata, i_m_rresp, i_m_rlast, i_m_rvalid,
        input  o_m_rready
    );

endinterface

// File: rtl/axi_reg_slice_skid_buf.sv
// Generic 2-entry skid buffer: both handshake outputs come straight from
// flops, so neither side sees a combinational path from the other.
module skid_buf
    import veerwolf_axi_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    occ_t             occ;
    occ_t             occ_next;
    logic             ready_en;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] skid;
    logic             push;
    logic             pop;

    assign push = up_valid & up_ready;
    assign pop  = dn_valid & dn_ready;

    // ready_en holds readies low for one cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= OCC_EMPTY;
            ready_en <= 1'b0;
        end else begin
            occ      <= occ_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (push) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_next = OCC_FULL;
                else if (pop && !push) occ_next = OCC_EMPTY;
            end
            OCC_FULL:  if (pop) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    always_comb begin
        up_ready = (occ != OCC_FULL) && ready_en;
        dn_valid = (occ != OCC_EMPTY);
        dn_data  = head;
    end

    // Payload flops carry no reset; their content only matters while occupied.
    always_ff @(posedge clk) begin
        case (occ)
            OCC_EMPTY: if (push) head <= up_data;
            OCC_ONE: begin
                if (push && pop) head <= up_data;
                else if (push)   skid <= up_data;
            end
            OCC_FULL:  if (pop) head <= skid;
            default: ;
        endcase
    end

endmodule

// File: rtl/axi_reg_slice.sv
// AXI register slice: five independent skid buffers, AW/AR/W toward the
// memory wrapper and B/R back toward the master.
module axi_reg_slice
    import veerwolf_axi_pkg::*;
#(
    parameter int ID_WIDTH = 1
) (
    input logic              clk,
    input logic              rst_n,
    axi_reg_slice_if.slave   bus
);

    localparam int AX_W = ax_width(ID_WIDTH);
    localparam int B_W  = b_width(ID_WIDTH);
    localparam int R_W  = r_width(ID_WIDTH);

    logic [AX_W-1:0]    aw_up;
    logic [AX_W-1:0]    aw_dn;
    logic [AX_W-1:0]    ar_up;
    logic [AX_W-1:0]    ar_dn;
    logic [W_WIDTH-1:0] w_up;
    logic [W_WIDTH-1:0] w_dn;
    logic [B_W-1:0]     b_up;
    logic [B_W-1:0]     b_dn;
    logic [R_W-1:0]     r_up;
    logic [R_W-1:0]     r_dn;

    assign aw_up = {bus.i_awid, bus.i_awaddr, bus.i_awlen, bus.i_awsize, bus.i_awburst};
    assign {bus.o_m_awid, bus.o_m_awaddr, bus.o_m_awlen, bus.o_m_awsize, bus.o_m_awburst} = aw_dn;

    assign ar_up = {bus.i_arid, bus.i_araddr, bus.i_arlen, bus.i_arsize, bus.i_arburst};
    assign {bus.o_m_arid, bus.o_m_araddr, bus.o_m_arlen, bus.o_m_arsize, bus.o_m_arburst} = ar_dn;

    assign w_up = {bus.i_wdata, bus.i_wstrb, bus.i_wlast};
    assign {bus.o_m_wdata, bus.o_m_wstrb, bus.o_m_wlast} = w_dn;

    // B and R enter from the memory side and leave toward the master.
    assign b_up = {bus.i_m_bid, bus.i_m_bresp};
    assign {bus.o_bid, bus.o_bresp} = b_dn;

    assign r_up = {bus.i_m_rid, bus.i_m_rdata, bus.i_m_rresp, bus.i_m_rlast};
    assign {bus.o_rid, bus.o_rdata, bus.o_rresp, bus.o_rlast} = r_dn;

    skid_buf #(.WIDTH(AX_W)) u_aw (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.i_awvalid),
        .up_ready (bus.o_awready),
        .up_data  (aw_up),
        .dn_valid (bus.o_m_awvalid),
        .dn_ready (bus.i_m_awready),
        .dn_data  (aw_dn)
    );

    skid_buf #(.WIDTH(AX_W)) u_ar (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.i_arvalid),
        .up_ready (bus.o_arready),
        .up_data  (ar_up),
        .dn_valid (bus.o_m_arvalid),
        .dn_ready (bus.i_m_arready),
        .dn_data  (ar_dn)
    );

    skid_buf #(.WIDTH(W_WIDTH)) u_w (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.i_wvalid),
        .up_ready (bus.o_wready),
        .up_data  (w_up),
        .dn_valid (bus.o_m_wvalid),
        .dn_ready (bus.i_m_wready),
        .dn_data  (w_dn)
    );

    skid_buf #(.WIDTH(B_W)) u_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.i_m_bvalid),
        .up_ready (bus.o_m_bready),
        .up_data  (b_up),
        .dn_valid (bus.o_bvalid),
        .dn_ready (bus.i_bready),
        .dn_data  (b_dn)
    );

    skid_buf #(.WIDTH(R_W)) u_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .up_valid (bus.i_m_rvalid),
        .up_ready (bus.o_m_rready),
        .up_data  (r_up),
        .dn_valid (bus.o_rvalid),
        .dn_ready (bus.i_rready),
        .dn_data  (r_dn)
    );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Bench for axi_reg_slice: per-channel FIFO reference model fed on every
// input handshake and drained by a monitor on every output handshake.
module tb_axi_reg_slice;
    import veerwolf_axi_pkg::*;

    localparam int ID_W = 4;
    localparam int AX_W = ax_width(ID_W);
    localparam int B_W  = b_width(ID_W);
    localparam int R_W  = r_width(ID_W);
    localparam int NCH  = 5;

    logic clk;
    logic rst_n;
    logic mon_on;

    // Channel index: 0 AW, 1 AR, 2 W, 3 B, 4 R.
    logic [NCH-1:0] in_valid;
    logic [NCH-1:0] out_ready;
    logic [127:0]   in_data [NCH];
    wire  [NCH-1:0] in_ready;
    wire  [NCH-1:0] out_valid;
    wire  [127:0]   out_data [NCH];
    int             ready_mode [NCH];

    logic [127:0] model [NCH][64];
    int           wr [NCH];
    int           rd [NCH];
    int           pushes [NCH];
    int           pops [NCH];
    int           total;
    int           passed;
    string        names [NCH] = '{"aw", "ar", "w", "b", "r"};

    axi_reg_slice_if #(.ID_WIDTH(ID_W)) bus ();

    axi_reg_slice #(.ID_WIDTH(ID_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign {bus.i_awid, bus.i_awaddr, bus.i_awlen, bus.i_awsize, bus.i_awburst} = in_data[0][AX_W-1:0];
    assign bus.i_awvalid   = in_valid[0];
    assign in_ready[0]     = bus.o_awready;
    assign out_valid[0]    = bus.o_m_awvalid;
    assign out_data[0]     = 128'({bus.o_m_awid, bus.o_m_awaddr, bus.o_m_awlen, bus.o_m_awsize, bus.o_m_awburst});
    assign bus.i_m_awready = out_ready[0];

    assign {bus.i_arid, bus.i_araddr, bus.i_arlen, bus.i_arsize, bus.i_arburst} = in_data[1][AX_W-1:0];
    assign bus.i_arvalid   = in_valid[1];
    assign in_ready[1]     = bus.o_arready;
    assign out_valid[1]    = bus.o_m_arvalid;
    assign out_data[1]     = 128'({bus.o_m_arid, bus.o_m_araddr, bus.o_m_arlen, bus.o_m_arsize, bus.o_m_arburst});
    assign bus.i_m_arready = out_ready[1];

    assign {bus.i_wdata, bus.i_wstrb, bus.i_wlast} = in_data[2][W_WIDTH-1:0];
    assign bus.i_wvalid    = in_valid[2];
    assign in_ready[2]     = bus.o_wready;
    assign out_valid[2]    = bus.o_m_wvalid;
    assign out_data[2]     = 128'({bus.o_m_wdata, bus.o_m_wstrb, bus.o_m_wlast});
    assign bus.i_m_wready  = out_ready[2];

    assign {bus.i_m_bid, bus.i_m_bresp} = in_data[3][B_W-1:0];
    assign bus.i_m_bvalid  = in_valid[3];
    assign in_ready[3]     = bus.o_m_bready;
    assign out_valid[3]    = bus.o_bvalid;
    assign out_data[3]     = 128'({bus.o_bid, bus.o_bresp});
    assign bus.i_bready    = out_ready[3];

    assign {bus.i_m_rid, bus.i_m_rdata, bus.i_m_rresp, bus.i_m_rlast} = in_data[4][R_W-1:0];
    assign bus.i_m_rvalid  = in_valid[4];
    assign in_ready[4]     = bus.o_m_rready;
    assign out_valid[4]    = bus.o_rvalid;
    assign out_data[4]     = 128'({bus.o_rid, bus.o_rdata, bus.o_rresp, bus.o_rlast});
    assign bus.i_rready    = out_ready[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [127:0] chMask(input int ch);
        int w;
        case (ch)
            0, 1:    w = AX_W;
            2:       w = W_WIDTH;
            3:       w = B_W;
            default: w = R_W;
        endcase
        return (128'(1) << w) - 128'(1);
    endfunction

    function automatic logic [127:0] rndData(input int ch);
        return {$urandom, $urandom, $urandom, $urandom} & chMask(ch);
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        total++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    endtask

    // Called at posedge+1; the beat is offered until the slice accepts it.
    task automatic applyStimulus(input int ch, input logic [127:0] d, input int budget);
        bit ok;
        ok = 1'b0;
        in_data[ch]  = d & chMask(ch);
        in_valid[ch] = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (in_ready[ch]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid[ch] = 1'b0;
        checkOutput($sformatf("%s_accept", names[ch]), 128'(ok), 128'(1));
    endtask

    task automatic soakChannel(input int ch, input int beats);
        for (int i = 0; i < beats; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            applyStimulus(ch, rndData(ch), 60);
        end
    endtask

    task automatic drainAll();
        int left;
        for (int ch = 0; ch < NCH; ch++) ready_mode[ch] = 1;
        left = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            left = 0;
            for (int ch = 0; ch < NCH; ch++) left += wr[ch] - rd[ch];
            if (left == 0) break;
        end
        checkOutput("drain_all", 128'(left), 128'(0));
    endtask

    always @(posedge clk) begin
        #2;
        for (int ch = 0; ch < NCH; ch++)
            out_ready[ch] = (ready_mode[ch] == 2) ? 1'($urandom_range(0, 1)) : (ready_mode[ch] == 1);
    end

    // Model view: the slice holds wr-rd beats; it is valid when non-empty
    // and ready while fewer than two beats are held.
    always @(negedge clk) begin
        int cnt;
        if (mon_on) begin
            for (int ch = 0; ch < NCH; ch++) begin
                cnt = wr[ch] - rd[ch];
                checkOutput($sformatf("%s_valid", names[ch]), 128'(out_valid[ch]), 128'(cnt != 0));
                checkOutput($sformatf("%s_ready", names[ch]), 128'(in_ready[ch]), 128'(cnt < 2));
                if (out_valid[ch] && cnt > 0) begin
                    checkOutput($sformatf("%s_data", names[ch]), out_data[ch], model[ch][rd[ch] % 64]);
                    if (out_ready[ch]) begin
                        rd[ch]++;
                        pops[ch]++;
                    end
                end
                if (in_valid[ch] && in_ready[ch]) begin
                    model[ch][wr[ch] % 64] = in_data[ch];
                    wr[ch]++;
                    pushes[ch]++;
                end
            end
        end
    end

    initial begin
        int base;
        int base_b [NCH];
        logic [127:0] beat_a;
        logic [127:0] beat_b;

        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        mon_on = 1'b0;
        in_valid = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            in_data[ch]    = '0;
            ready_mode[ch] = 0;
            wr[ch]         = 0;
            rd[ch]         = 0;
            pushes[ch]     = 0;
            pops[ch]       = 0;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            checkOutput($sformatf("%s_reset_valid", names[ch]), 128'(out_valid[ch]), 128'(0));
            checkOutput($sformatf("%s_reset_ready", names[ch]), 128'(in_ready[ch]), 128'(0));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checkOutput("ready_first_cycle_after_release", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1 mon_on = 1'b1;
        @(negedge clk);
        #1 checkOutput("ready_second_edge_after_release", 128'(in_ready), 128'(5'h1f));
        @(posedge clk);
        #1;

        // Streaming AR: every beat must be taken on its first offer.
        ready_mode[1] = 1;
        @(posedge clk);
        #1;
        base = pops[1];
        for (int i = 0; i < 16; i++) applyStimulus(1, rndData(1), 1);
        repeat (3) @(posedge clk);
        #1 checkOutput("ar_stream_count", 128'(pops[1] - base), 128'(16));

        // W backpressure: two beats fit, the third waits.
        base_b[2] = pushes[2];
        base = pops[2];
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(2, 128'(i) | (rndData(2) << 8), 20);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                checkOutput("w_accepted_while_stalled", 128'(pushes[2] - base_b[2]), 128'(2));
                checkOutput("w_ready_when_full", 128'(in_ready[2]), 128'(0));
                ready_mode[2] = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1 checkOutput("w_drained_count", 128'(pops[2] - base), 128'(3));

        // R: pop A and push B in the same cycle at occupancy one.
        ready_mode[4] = 0;
        @(posedge clk);
        #1;
        beat_a = rndData(4);
        beat_b = rndData(4);
        applyStimulus(4, beat_a, 5);
        ready_mode[4] = 1;
        applyStimulus(4, beat_b, 5);
        @(negedge clk);
        checkOutput("r_valid_continuous", 128'(out_valid[4]), 128'(1));
        checkOutput("r_head_is_b", out_data[4], beat_b);
        @(posedge clk);
        #1;

        // W held full while the other four channels each move four beats.
        ready_mode[2] = 0;
        @(posedge clk);
        #1;
        applyStimulus(2, rndData(2), 5);
        applyStimulus(2, rndData(2), 5);
        for (int ch = 0; ch < NCH; ch++) base_b[ch] = pops[ch];
        base = pushes[2];
        ready_mode[0] = 2;
        ready_mode[1] = 2;
        ready_mode[3] = 2;
        ready_mode[4] = 2;
        fork
            soakChannel(0, 4);
            soakChannel(1, 4);
            soakChannel(3, 4);
            soakChannel(4, 4);
        join
        ready_mode[0] = 1;
        ready_mode[1] = 1;
        ready_mode[3] = 1;
        ready_mode[4] = 1;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("indep_aw_done", 128'(pops[0] - base_b[0]), 128'(4));
        checkOutput("indep_ar_done", 128'(pops[1] - base_b[1]), 128'(4));
        checkOutput("indep_b_done", 128'(pops[3] - base_b[3]), 128'(4));
        checkOutput("indep_r_done", 128'(pops[4] - base_b[4]), 128'(4));
        checkOutput("indep_w_untouched", 128'(pops[2] - base_b[2]), 128'(0));
        checkOutput("indep_w_no_push", 128'(pushes[2] - base), 128'(0));
        drainAll();

        // Randomised soak on all channels with random downstream readiness.
        for (int ch = 0; ch < NCH; ch++) ready_mode[ch] = 2;
        @(posedge clk);
        #1;
        fork
            soakChannel(0, 40);
            soakChannel(1, 40);
            soakChannel(2, 40);
            soakChannel(3, 40);
            soakChannel(4, 40);
        join
        drainAll();

        // Reset while W is full behind an AW with awlen=7.
        for (int ch = 0; ch < NCH; ch++) ready_mode[ch] = 1;
        ready_mode[2] = 0;
        @(posedge clk);
        #1;
        applyStimulus(0, 128'({ID_W'(3), 32'h1000_0000, 8'd7, 3'd3, 2'd1}), 5);
        applyStimulus(2, rndData(2), 5);
        applyStimulus(2, rndData(2), 5);
        mon_on = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midreset_valids", 128'(out_valid), 128'(0));
        checkOutput("midreset_readies", 128'(in_ready), 128'(0));
        for (int ch = 0; ch < NCH; ch++) rd[ch] = wr[ch];
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode[2] = 1;
        @(posedge clk);
        #1 mon_on = 1'b1;
        base = pops[2];
        repeat (5) @(posedge clk);
        #1 checkOutput("w_no_stale_beat_after_reset", 128'(pops[2] - base), 128'(0));
        applyStimulus(2, rndData(2), 5);
        repeat (3) @(posedge clk);
        #1 checkOutput("w_new_beat_after_reset", 128'(pops[2] - base), 128'(1));
        drainAll();

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
